// File: rtl/axi_full_burst_master.sv
// -----------------------------------------------------------------------------
// axi_full_burst_master
//
// AXI4-full master that runs one write burst and one read burst at a time on
// behalf of a user-logic client. Each burst takes a run-time address (offset
// from C_M_TARGET_SLAVE_BASE_ADDR) and a run-time AXI length (beats-1). The
// write and read engines are independent and may be active simultaneously.
// User data moves over plain valid/ready streams that are wired straight
// through to the W and R channels, so the data path adds no latency.
//
// Optional build macro:
//   AXI_BURST_4K_CHECK_EN - reject any request whose burst would cross a 4 KB
//                           boundary; a rejected request issues no address
//                           phase and pulses done+err in the following cycle.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARST          clock, synchronous active-high reset
//   i_wr_req/addr/len               write command (sampled only when idle)
//   i_wr_data/valid, o_wr_ready     write-data stream into the W channel
//   o_wr_busy/done/err              write engine status (done/err 1-cycle)
//   i_rd_req/addr/len               read command (sampled only when idle)
//   o_rd_data/valid/last, i_rd_ready read-data stream out of the R channel
//   o_rd_busy/done/err              read engine status (done/err 1-cycle)
//   M_AXI_AW*/W*/B*/AR*/R*          AXI4 master channels
// -----------------------------------------------------------------------------
module axi_full_burst_master #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
    parameter int          C_M_AXI_ID_WIDTH           = 1,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARST,

    // write command and data stream
    input  logic                            i_wr_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [7:0]                      i_wr_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_wr_data,
    input  logic                            i_wr_valid,
    output logic                            o_wr_ready,
    output logic                            o_wr_busy,
    output logic                            o_wr_done,
    output logic                            o_wr_err,

    // read command and data stream
    input  logic                            i_rd_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_rd_addr,
    input  logic [7:0]                      i_rd_len,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rd_data,
    output logic                            o_rd_valid,
    output logic                            o_rd_last,
    input  logic                            i_rd_ready,
    output logic                            o_rd_busy,
    output logic                            o_rd_done,
    output logic                            o_rd_err,

    // AW channel
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    // W channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    // B channel
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    // AR channel
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    // R channel
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR =
        C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR);

    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R}       rd_state_t;

    wr_state_t                         wr_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_q;
    logic [7:0]                        awlen_q;
    logic                              awvalid_q;
    logic                              bready_q;
    logic [7:0]                        wr_cnt;
    logic                              wr_busy_q, wr_done_q, wr_err_q;

    rd_state_t                         rd_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr_q;
    logic [7:0]                        arlen_q;
    logic                              arvalid_q;
    logic [7:0]                        rd_cnt;
    logic                              rd_resp_err;
    logic                              rd_busy_q, rd_done_q, rd_err_q;

    // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_eff, rd_addr_eff;
    assign wr_addr_eff = i_wr_addr + BASE_ADDR;
    assign rd_addr_eff = i_rd_addr + BASE_ADDR;

    logic wr_reject, rd_reject;
`ifdef AXI_BURST_4K_CHECK_EN
    // Offset of the first byte past the burst within its 4 KB page; anything
    // beyond 4096 means the burst would spill into the next page.
    function automatic logic crosses_4k(input logic [C_M_AXI_ADDR_WIDTH-1:0] addr,
                                        input logic [7:0] len);
        logic [13:0] end_off;
        end_off = {2'b00, addr[11:0]} + ((14'(len) + 14'd1) * 14'(STRB_W));
        return end_off > 14'd4096;
    endfunction
    assign wr_reject = crosses_4k(wr_addr_eff, i_wr_len);
    assign rd_reject = crosses_4k(rd_addr_eff, i_rd_len);
`else
    assign wr_reject = 1'b0;
    assign rd_reject = 1'b0;
`endif

    // ---------------- fixed AXI attributes ----------------
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWSIZE  = AXI_SIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0010;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARSIZE  = AXI_SIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0010;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;

    // IDs are not used: only one burst per direction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

    // ---------------- write engine ----------------
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign o_wr_busy     = wr_busy_q;
    assign o_wr_done     = wr_done_q;
    assign o_wr_err      = wr_err_q;

    // W path is a straight pass-through, gated only by being in the W phase.
    assign M_AXI_WDATA  = i_wr_data;
    assign M_AXI_WVALID = (wr_state == WR_W) && i_wr_valid;
    assign o_wr_ready   = (wr_state == WR_W) && M_AXI_WREADY;
    assign M_AXI_WLAST  = (wr_state == WR_W) && (wr_cnt == awlen_q);

    logic w_hs;
    assign w_hs = M_AXI_WVALID && M_AXI_WREADY;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARST) begin
            wr_state  <= WR_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            wr_cnt    <= '0;
            wr_busy_q <= 1'b0;
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    if (i_wr_req) begin
                        if (wr_reject) begin
                            wr_done_q <= 1'b1;
                            wr_err_q  <= 1'b1;
                        end else begin
                            awaddr_q  <= wr_addr_eff;
                            awlen_q   <= i_wr_len;
                            awvalid_q <= 1'b1;
                            wr_busy_q <= 1'b1;
                            wr_cnt    <= '0;
                            wr_state  <= WR_AW;
                        end
                    end
                end
                WR_AW: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        wr_state  <= WR_W;
                    end
                end
                WR_W: begin
                    if (w_hs) begin
                        wr_cnt <= wr_cnt + 8'd1;
                        if (wr_cnt == awlen_q) begin
                            bready_q <= 1'b1;
                            wr_state <= WR_B;
                        end
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID) begin
                        bready_q  <= 1'b0;
                        wr_busy_q <= 1'b0;
                        wr_done_q <= 1'b1;
                        wr_err_q  <= (M_AXI_BRESP != RESP_OKAY);
                        wr_cnt    <= '0;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign o_rd_busy     = rd_busy_q;
    assign o_rd_done     = rd_done_q;
    assign o_rd_err      = rd_err_q;

    assign o_rd_data    = M_AXI_RDATA;
    assign o_rd_valid   = (rd_state == RD_R) && M_AXI_RVALID;
    assign o_rd_last    = (rd_state == RD_R) && M_AXI_RLAST;
    assign M_AXI_RREADY = (rd_state == RD_R) && i_rd_ready;

    logic r_hs, rd_at_len;
    assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
    assign rd_at_len = (rd_cnt == arlen_q);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARST) begin
            rd_state    <= RD_IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rd_cnt      <= '0;
            rd_resp_err <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (i_rd_req) begin
                        if (rd_reject) begin
                            rd_done_q <= 1'b1;
                            rd_err_q  <= 1'b1;
                        end else begin
                            araddr_q    <= rd_addr_eff;
                            arlen_q     <= i_rd_len;
                            arvalid_q   <= 1'b1;
                            rd_busy_q   <= 1'b1;
                            rd_cnt      <= '0;
                            rd_resp_err <= 1'b0;
                            rd_state    <= RD_AR;
                        end
                    end
                end
                RD_AR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rd_state  <= RD_R;
                    end
                end
                RD_R: begin
                    if (r_hs) begin
                        rd_cnt <= rd_cnt + 8'd1;
                        if (M_AXI_RRESP != RESP_OKAY) begin
                            rd_resp_err <= 1'b1;
                        end
                        // Stop at whichever comes first: the slave's RLAST or
                        // our own beat count. Disagreement is a protocol error.
                        if (M_AXI_RLAST || rd_at_len) begin
                            rd_busy_q <= 1'b0;
                            rd_done_q <= 1'b1;
                            rd_err_q  <= rd_resp_err || (M_AXI_RRESP != RESP_OKAY)
                                         || (M_AXI_RLAST != rd_at_len);
                            rd_cnt    <= '0;
                            rd_state  <= RD_IDLE;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_full_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axi_full_burst_master
//
// Bench for axi_full_burst_master. A behavioural AXI slave and the user-side
// stream drivers live in one negedge-driven process; the main process issues
// commands and pushes the expected AW/AR addresses, W data and user read data
// onto scoreboard queues, which are popped as the handshakes are observed.
// -----------------------------------------------------------------------------
module tb_axi_full_burst_master;

    localparam logic [31:0] BASE = 32'h40000000;

    logic        M_AXI_ACLK = 1'b0;
    logic        M_AXI_ARST;

    logic        i_wr_req, i_wr_valid, o_wr_ready, o_wr_busy, o_wr_done, o_wr_err;
    logic [31:0] i_wr_addr, i_wr_data;
    logic [7:0]  i_wr_len;
    logic        i_rd_req, o_rd_valid, o_rd_last, i_rd_ready, o_rd_busy, o_rd_done, o_rd_err;
    logic [31:0] i_rd_addr, o_rd_data;
    logic [7:0]  i_rd_len;

    logic [0:0]  M_AXI_AWID, M_AXI_BID, M_AXI_ARID, M_AXI_RID;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWLOCK, M_AXI_ARLOCK;
    logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS, M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    axi_full_burst_master dut (
        .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARST(M_AXI_ARST),
        .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_len(i_wr_len),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_wr_busy(o_wr_busy), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
        .i_rd_ready(i_rd_ready), .o_rd_busy(o_rd_busy), .o_rd_done(o_rd_done),
        .o_rd_err(o_rd_err),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [31:0] exp_aw_addr_q[$];
    logic [7:0]  exp_aw_len_q[$];
    logic [31:0] exp_ar_addr_q[$];
    logic [7:0]  exp_ar_len_q[$];
    logic [31:0] exp_w_q[$];
    logic [32:0] exp_rd_q[$];      // {last, data}
    logic [31:0] src_w_q[$];       // user write stream still to be offered

    // ---------------- slave / stream knobs and state ----------------
    logic [1:0]  bresp_val = 2'b00;
    logic [31:0] r_base = '0;
    int          early_last = -1;     // beat index carrying RLAST, -1 = at ARLEN
    int          rd_stall_after = -1; // drop i_rd_ready after this many user beats
    int          rd_user_beats = 0;

    int          w_beat = 0, r_beat = 0, r_last_beat = 0, stall_left = 0;
    logic [7:0]  aw_len_rcv = '0;
    bit          b_pend = 0, r_act = 0;
    bit          hs_aw = 0, hs_w = 0, hs_w_last = 0, hs_b = 0, hs_ar = 0;
    bit          hs_r = 0, hs_r_last = 0, hs_uw = 0, hs_ur = 0;
    int          aw_cnt = 0, wr_done_cnt = 0, rd_done_cnt = 0;
    logic        last_wr_err = 0, last_rd_err = 0;

    // Negedge +0: apply handshakes that happened at the edge just gone and
    // drive new inputs. Negedge +1: inputs settled, so any valid&ready seen
    // now is exactly the handshake of the coming posedge.
    initial begin
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b1;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_BID = '0;
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        M_AXI_RLAST = 1'b0; M_AXI_RID = '0;
        i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b1;
        forever begin
            @(negedge M_AXI_ACLK);
            if (M_AXI_ARST) begin
                b_pend = 0; r_act = 0; w_beat = 0; r_beat = 0; stall_left = 0;
                exp_aw_addr_q.delete(); exp_aw_len_q.delete(); exp_w_q.delete();
                exp_ar_addr_q.delete(); exp_ar_len_q.delete(); exp_rd_q.delete();
                src_w_q.delete();
            end else begin
                if (hs_aw) w_beat = 0;
                if (hs_w) begin
                    w_beat++;
                    if (hs_w_last) b_pend = 1;
                end
                if (hs_b) b_pend = 0;
                if (hs_ar) begin r_act = 1; r_beat = 0; end
                if (hs_r) begin
                    if (hs_r_last) r_act = 0;
                    else r_beat++;
                end
                if (hs_uw && src_w_q.size() > 0) void'(src_w_q.pop_front());
                if (hs_ur) begin
                    rd_user_beats++;
                    if (rd_user_beats == rd_stall_after) stall_left = 3;
                end
            end
            {hs_aw, hs_w, hs_w_last, hs_b, hs_ar, hs_r, hs_r_last, hs_uw, hs_ur} = '0;

            M_AXI_BVALID = b_pend;
            M_AXI_BRESP  = bresp_val;
            M_AXI_RVALID = r_act;
            M_AXI_RDATA  = r_base + 32'(r_beat);
            M_AXI_RLAST  = r_act && (r_beat == r_last_beat);
            i_wr_valid   = (src_w_q.size() > 0);
            i_wr_data    = (src_w_q.size() > 0) ? src_w_q[0] : 32'h0;
            i_rd_ready   = (stall_left == 0);
            if (stall_left > 0) stall_left--;

            #1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                hs_aw = 1; aw_cnt++;
                aw_len_rcv = M_AXI_AWLEN;
                if (exp_aw_addr_q.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    check("awaddr", M_AXI_AWADDR, exp_aw_addr_q.pop_front());
                    check("awlen", M_AXI_AWLEN, exp_aw_len_q.pop_front());
                    check("awsize_burst_cache", {M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE},
                          {3'd2, 2'b01, 4'b0010});
                end
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                hs_w = 1; hs_w_last = M_AXI_WLAST;
                if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
                else check("wdata", M_AXI_WDATA, exp_w_q.pop_front());
                check("wlast", M_AXI_WLAST, (w_beat == int'(aw_len_rcv)));
            end
            hs_b = M_AXI_BVALID && M_AXI_BREADY;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                hs_ar = 1;
                r_last_beat = (early_last >= 0) ? early_last : int'(M_AXI_ARLEN);
                if (exp_ar_addr_q.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    check("araddr", M_AXI_ARADDR, exp_ar_addr_q.pop_front());
                    check("arlen", M_AXI_ARLEN, exp_ar_len_q.pop_front());
                end
            end
            hs_r = M_AXI_RVALID && M_AXI_RREADY;
            hs_r_last = M_AXI_RLAST;
            hs_uw = i_wr_valid && o_wr_ready;
            if (o_rd_valid && i_rd_ready) begin
                hs_ur = 1;
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_last_data", {o_rd_last, o_rd_data}, exp_rd_q.pop_front());
            end
            if (r_act && !i_rd_ready) check("rready_follows", M_AXI_RREADY, 0);
            if (o_wr_done) begin wr_done_cnt++; last_wr_err = o_wr_err; end
            if (o_rd_done) begin rd_done_cnt++; last_rd_err = o_rd_err; end
        end
    end

    // ---------------- main sequence helpers ----------------
    task automatic tick();
        @(negedge M_AXI_ACLK);
        #2;
    endtask

    task automatic wait_wr_done(input int target, input string tag);
        int n;
        n = 0;
        while (wr_done_cnt < target && n < 300) begin tick(); n++; end
        check(tag, (wr_done_cnt >= target), 1);
    endtask

    task automatic wait_rd_done(input int target, input string tag);
        int n;
        n = 0;
        while (rd_done_cnt < target && n < 300) begin tick(); n++; end
        check(tag, (rd_done_cnt >= target), 1);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0);
        exp_aw_addr_q.push_back(addr + BASE);
        exp_aw_len_q.push_back(len);
        for (int i = 0; i <= int'(len); i++) begin
            src_w_q.push_back(d0 + 32'(i));
            exp_w_q.push_back(d0 + 32'(i));
        end
    endtask

    task automatic push_rd(input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] base, input int early);
        int beats;
        logic [31:0] d;
        r_base = base; early_last = early; rd_user_beats = 0;
        exp_ar_addr_q.push_back(addr + BASE);
        exp_ar_len_q.push_back(len);
        beats = (early >= 0) ? early + 1 : int'(len) + 1;
        for (int i = 0; i < beats; i++) begin
            d = base + 32'(i);
            exp_rd_q.push_back({(i == beats - 1), d});
        end
    endtask

    task automatic issue_wr(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0);
        push_wr(addr, len, d0);
        i_wr_req = 1'b1; i_wr_addr = addr; i_wr_len = len;
        tick();
        i_wr_req = 1'b0;
    endtask

    task automatic issue_rd(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input int early);
        push_rd(addr, len, base, early);
        i_rd_req = 1'b1; i_rd_addr = addr; i_rd_len = len;
        tick();
        i_rd_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int wr_target = 0, rd_target = 0, aw_before = 0;

    initial begin
        M_AXI_ARST = 1'b1;
        i_wr_req = 1'b0; i_wr_addr = '0; i_wr_len = '0;
        i_rd_req = 1'b0; i_rd_addr = '0; i_rd_len = '0;
        repeat (3) tick();

        // reset state
        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid_wlast", {M_AXI_WVALID, M_AXI_WLAST}, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_user_stream", {o_wr_ready, o_rd_valid, o_rd_last}, 0);
        check("rst_wr_status", {o_wr_busy, o_wr_done, o_wr_err}, 0);
        check("rst_rd_status", {o_rd_busy, o_rd_done, o_rd_err}, 0);
        M_AXI_ARST = 1'b0;
        tick();

        // 16-beat write, data 1..16
        issue_wr(32'h100, 8'd15, 32'd1);
        check("wr1_awvalid_n1", M_AXI_AWVALID, 1);
        check("wr1_busy", o_wr_busy, 1);
        wr_target++;
        wait_wr_done(wr_target, "wr1_done");
        check("wr1_err", last_wr_err, 0);
        tick();
        check("wr1_done_pulse", {o_wr_done, o_wr_busy}, 0);

        // 16-beat read with a 3-cycle user stall after beat 5
        rd_stall_after = 5;
        issue_rd(32'h100, 8'd15, 32'd1, -1);
        check("rd1_arvalid_n1", M_AXI_ARVALID, 1);
        rd_target++;
        wait_rd_done(rd_target, "rd1_done");
        check("rd1_err", last_rd_err, 0);
        check("rd1_all_beats", exp_rd_q.size(), 0);
        rd_stall_after = -1;
        tick();

        // single-beat write answered with SLVERR, then single-beat read
        bresp_val = 2'b10;
        issue_wr(32'h180, 8'd0, 32'hDEAD0000);
        wr_target++;
        wait_wr_done(wr_target, "wr0_done");
        check("wr0_slverr", last_wr_err, 1);
        bresp_val = 2'b00;
        issue_rd(32'h180, 8'd0, 32'h55, -1);
        rd_target++;
        wait_rd_done(rd_target, "rd0_done");
        check("rd0_err", last_rd_err, 0);
        tick();

        // simultaneous write+read; second write request while busy is ignored
        aw_before = aw_cnt;
        push_wr(32'h300, 8'd3, 32'hA0);
        push_rd(32'h400, 8'd3, 32'h70, -1);
        i_wr_req = 1'b1; i_wr_addr = 32'h300; i_wr_len = 8'd3;
        i_rd_req = 1'b1; i_rd_addr = 32'h400; i_rd_len = 8'd3;
        tick();
        i_rd_req = 1'b0; i_wr_addr = 32'h500;
        tick();
        i_wr_req = 1'b0;
        wr_target++; rd_target++;
        wait_wr_done(wr_target, "dual_wr_done");
        wait_rd_done(rd_target, "dual_rd_done");
        check("dual_errs", {last_wr_err, last_rd_err}, 0);
        repeat (4) tick();
        check("dual_one_aw", aw_cnt - aw_before, 1);

        // slave ends a len=7 read early with RLAST on beat 4
        issue_rd(32'h600, 8'd7, 32'h200, 3);
        rd_target++;
        wait_rd_done(rd_target, "early_done");
        check("early_err", last_rd_err, 1);
        check("early_beats", exp_rd_q.size(), 0);
        early_last = -1;
        tick();

        // burst that would cross a 4 KB page
`ifdef AXI_BURST_4K_CHECK_EN
        i_wr_req = 1'b1; i_wr_addr = 32'hFF0; i_wr_len = 8'd7;
        tick();
        i_wr_req = 1'b0;
        check("4k_no_awvalid", M_AXI_AWVALID, 0);
        check("4k_done_err", {o_wr_done, o_wr_err, o_wr_busy}, 3'b110);
        wr_target++;
        tick();
        check("4k_no_aw_later", M_AXI_AWVALID, 0);
`else
        issue_wr(32'hFF0, 8'd7, 32'h1000);
        check("4k_issued", M_AXI_AWVALID, 1);
        wr_target++;
        wait_wr_done(wr_target, "4k_done");
        check("4k_err", last_wr_err, 0);
`endif
        tick();
        check("sb_drained", exp_aw_addr_q.size() + exp_w_q.size() + exp_ar_addr_q.size()
              + exp_rd_q.size(), 0);

        // reset in the middle of a write burst (only 1 of 4 data words offered)
        exp_aw_addr_q.push_back(32'h200 + BASE);
        exp_aw_len_q.push_back(8'd3);
        src_w_q.push_back(32'h77);
        exp_w_q.push_back(32'h77);
        i_wr_req = 1'b1; i_wr_addr = 32'h200; i_wr_len = 8'd3;
        tick();
        i_wr_req = 1'b0;
        repeat (5) tick();
        check("midrst_busy_before", o_wr_busy, 1);
        M_AXI_ARST = 1'b1;
        tick();
        check("midrst_channels", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID}, 0);
        check("midrst_status", {o_wr_busy, o_wr_done, o_wr_err}, 0);
        M_AXI_ARST = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_full_burst_master.md
# axi_full_burst_master

Parametrised AXI4-full master that runs single write and read bursts on behalf of a user-logic client. Each burst has a run-time address and a run-time length. The write and read engines are independent and can be active at the same time. Data moves over simple valid/ready streams. The block sits between the application datapath and the AXI interconnect, and supersedes the fixed-length test-pattern master.

## Interface
Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h40000000, added to every user address
- C_M_AXI_ID_WIDTH, 1, width of the AXI ID fields; IDs are driven 0
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (32/64/128)

Ports:
- M_AXI_ACLK  in  1  the single clock
- M_AXI_ARST  in  1  reset; synchronous, active-high
- i_wr_req / i_wr_addr / i_wr_len  in  1 / ADDR / 8  write command; len uses AXI encoding (beats-1)
- i_wr_data / i_wr_valid  in  DATA / 1  write-data stream
- o_wr_ready  out  1  write-data stream ready
- o_wr_busy / o_wr_done / o_wr_err  out  1 each  write engine status
- i_rd_req / i_rd_addr / i_rd_len  in  1 / ADDR / 8  read command
- o_rd_data / o_rd_valid / o_rd_last  out  DATA / 1 / 1  read-data stream
- i_rd_ready  in  1  read-data stream ready
- o_rd_busy / o_rd_done / o_rd_err  out  1 each  read engine status
- M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R*  standard AXI4 master channel ports
  - Fixed values: ID=0, BURST=INCR, SIZE=log2(DATA/8), CACHE=4'b0010, LOCK/PROT/QOS=0, WSTRB all ones.

## Operation
Write FSM: IDLE → AW → W → B → IDLE.
- IDLE: when i_wr_req=1, latch addr+base and len, then go to AW. o_wr_busy=1 in every state except IDLE.
- AW: AWVALID=1 until the AWREADY handshake, then go to W.
- W: WVALID=i_wr_valid, o_wr_ready=WREADY, WDATA=i_wr_data.
  - An 8-bit beat counter increments on each handshake.
  - WLAST=1 when the counter equals len; the handshake on that beat moves the FSM to B.
- B: BREADY=1. On BVALID, go to IDLE and pulse o_wr_done for 1 cycle. o_wr_err pulses with it if BRESP≠OKAY.

Read FSM: IDLE → AR → R → IDLE.
- AR: ARVALID=1 until the ARREADY handshake.
- R: RREADY=i_rd_ready; o_rd_data/o_rd_valid/o_rd_last mirror RDATA/RVALID/RLAST.
  - The beat counter increments on each handshake.
  - The burst terminates on the handshake with RLAST=1 or the handshake with counter==len, whichever comes first. Go to IDLE and pulse o_rd_done.
  - o_rd_err pulses if any RRESP≠OKAY or if RLAST and counter==len do not coincide.

Rules:
- Requests are sampled only in IDLE; requests in any other state are ignored (not queued).
- Write and read requests in the same cycle are both accepted.
- The user must not make i_wr_valid depend on o_wr_ready.
- len=0 is a single beat: WLAST is asserted on the first beat.
- Address arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset: every VALID, READY and LAST output is 0; busy/done/err are 0; both FSMs are in IDLE; counters are 0.
- Reset mid-burst: the block returns to IDLE on the next edge and all channel valids drop. The system reset also covers the slave.
- Request sampled at edge N: AWVALID/ARVALID are high from N+1. Best-case AW-to-first-W is 1 cycle.
- Done/err pulse in the cycle after the final B/R handshake.
- W and R data paths are combinational pass-through, so there is zero added latency.

## Configuration
- AXI_BURST_4K_CHECK_EN defined:
  - A request with addr[11:0] + (len+1)·DATA/8 > 4096 is rejected.
  - On rejection no address phase is issued and the FSM stays in IDLE. done+err pulse at N+1.
- Undefined: no check is made and every request is issued as given.

## Test plan
- Write addr=0x100, len=15, data 1..16, slave always ready → AW at 0x40000100, AWLEN=15, WLAST on beat 16 only, done=1 with err=0.
- Read addr=0x100, len=15 → o_rd_data 1..16, o_rd_last on beat 16, done pulse; then hold i_rd_ready=0 for 3 cycles mid-burst → RREADY follows and no beat is lost.
- len=0 write and read → single beat with WLAST/RLAST on it; slave BRESP=SLVERR → o_wr_err=1.
- Simultaneous wr/rd requests; second wr request while busy → both bursts complete; the second wr request is ignored.
- Slave asserts RLAST on beat 4 of a len=7 read → burst ends, o_rd_done and o_rd_err pulse.
- With AXI_BURST_4K_CHECK_EN: addr=0xFF0, len=7, DATA=32 → no AWVALID, done+err at N+1. Without the macro → the burst is issued.
